// File: rtl/change_dispenser_if.sv
// change_dispenser_if: request, actuator and status signals between vending FSM and dispenser
interface change_dispenser_if #(
  parameter int COIN_W = 4
);
  logic              can_req;
  logic [COIN_W-1:0] coin_req;
  logic              req_ready;
  logic              can_out;
  logic              hopper_on;
  logic              coin_sense;
  logic              err_clr;
  logic              busy;
  logic              err;
  modport master (
    output can_req, coin_req, coin_sense, err_clr,
    input  req_ready, can_out, hopper_on, busy, err
  );
  modport slave (
    input  can_req, coin_req, coin_sense, err_clr,
    output req_ready, can_out, hopper_on, busy, err
  );
endinterface

// File: rtl/change_dispenser.sv
// change_dispenser: request FIFO feeding a can-solenoid / coin-hopper sequencer with hopper timeout.
// CHANGE_DISPENSER_STATS_EN adds saturating cans_total/coins_total outputs.
module change_dispenser #(
  parameter int COIN_W     = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int PULSE_CYC  = 4,
  parameter int TIMEOUT    = 64
) (
  input logic               clk,
  input logic               rst,
  change_dispenser_if.slave bus
`ifdef CHANGE_DISPENSER_STATS_EN
  ,
  output logic [15:0]       cans_total,
  output logic [15:0]       coins_total
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2((TIMEOUT > PULSE_CYC ? TIMEOUT : PULSE_CYC) + 1);
  localparam logic [TW-1:0] PULSE_LAST = TW'(PULSE_CYC - 1);
  localparam logic [TW-1:0] TIME_LAST = TW'(TIMEOUT - 1);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, LOAD, CAN, COIN, GAP, ERR} state_t;
  state_t state, nxt;

  logic [COIN_W:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       cnt;
  logic [COIN_W-1:0] coin_left, head_coin;
  logic [TW-1:0]     tmr;
  logic              push, pop, empty, head_can, sense;

  assign empty = cnt == '0;
  assign bus.req_ready = cnt != FULL_CNT;
  assign push = (bus.can_req | (bus.coin_req != '0)) & bus.req_ready;
  assign pop = state == LOAD;
  assign {head_can, head_coin} = mem[rd_ptr];
  assign sense = state == COIN && bus.coin_sense;

  // readiness comes from the registered count, so a same-cycle pop never frees a slot
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.can_req, bus.coin_req};
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      tmr <= '0;
      coin_left <= '0;
    end else begin
      state <= nxt;
      tmr <= (nxt != state) ? '0 : tmr + 1'b1;
      coin_left <= pop ? head_coin : coin_left - COIN_W'(sense && coin_left != '0);
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = empty ? IDLE : LOAD;
      LOAD: nxt = head_can ? CAN : (head_coin != '0 ? COIN : IDLE);
      CAN:  nxt = tmr != PULSE_LAST ? CAN : (coin_left != '0 ? COIN : IDLE);
      COIN: nxt = bus.coin_sense ? GAP : (tmr == TIME_LAST ? ERR : COIN);
      GAP:  nxt = coin_left != '0 ? COIN : (empty ? IDLE : LOAD);
      ERR:  nxt = bus.err_clr ? COIN : ERR;
      default: nxt = IDLE;
    endcase
  end

  assign bus.can_out = state == CAN;
  assign bus.hopper_on = state == COIN;
  assign bus.err = state == ERR;
  assign bus.busy = !empty || state != IDLE;

`ifdef CHANGE_DISPENSER_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      cans_total <= '0;
      coins_total <= '0;
    end else begin
      if (state == CAN && tmr == PULSE_LAST && cans_total != 16'hFFFF) cans_total <= cans_total + 1'b1;
      if (sense && coins_total != 16'hFFFF) coins_total <= coins_total + 1'b1;
    end
  end
`endif
endmodule
